fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Memory-side sequencer that sits directly upstream of the 32K x 8 program/data RAM.
- Owns the program counter and drives the RAM address, write-data and write-enable.
- Fetches 1- or 3-byte instructions and presents each to the execute stage over a valid/ready handshake.
- While an instruction is held, services single-byte data read/write requests from the execute stage on the same RAM port.

Parameters:
- ADDR_W, 15, RAM address width and PC width.
- DATA_W, 8, RAM data and opcode width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- mem_addr  out  15  RAM address (combinational from state)
- mem_wdata  out  8  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  8  RAM read data (asynchronous read, valid same cycle)
- instr_valid  out  1  instruction available
- instr_ready  in  1  execute stage accepts instruction
- instr_opcode  out  8  fetched opcode
- instr_operand  out  15  assembled operand address (0 for 1-byte instructions)
- jump_en  in  1  take jump; sampled only on handshake
- jump_target  in  15  new PC when jump_en
- data_req  in  1  data access request
- data_we  in  1  1 = write, 0 = read
- data_addr  in  15  data address
- data_wdata  in  8  data to write
- data_rdata  out  8  registered read result
- data_done  out  1  one-cycle pulse: access complete
- pc  out  15  current PC

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset state: pc=RESET_PC, state=FETCH_OP, instr_valid=0, instr_opcode=0, instr_operand=0, data_rdata=0, data_done=0. mem_we is forced 0 whenever rst=1, including reset asserted mid-write.
- Instruction length:
  - 3 bytes for opcodes 0x01 READ, 0x02 WRITE, 0x03 JPNZ.
  - 1 byte for all other opcodes, including unknown ones. No decode error is raised.
- Operand format: big-endian. operand[14:8] = hi byte [6:0]; hi byte bit 7 is ignored. operand[7:0] = lo byte.
- State FETCH_OP: mem_addr=pc. At the clock edge: opcode<=mem_rdata, pc<=pc+1, operand<=0. Next state is FETCH_HI for a 3-byte opcode, otherwise ISSUE with instr_valid<=1.
- State FETCH_HI: mem_addr=pc. At the edge: operand[14:8]<=mem_rdata[6:0], pc<=pc+1, next state FETCH_LO.
- State FETCH_LO: mem_addr=pc. At the edge: operand[7:0]<=mem_rdata, pc<=pc+1, instr_valid<=1, next state ISSUE.
- State ISSUE:
  - instr_valid=1. opcode and operand are held stable until the handshake.
  - mem_addr=pc, mem_we=0.
  - Handshake = instr_ready=1 and no data access being accepted this cycle. On handshake: instr_valid<=0, pc<=jump_target if jump_en else unchanged, next state FETCH_OP.
  - jump_en and jump_target are ignored outside the handshake cycle.
- Data access:
  - Accepted only in ISSUE when data_req=1 and data_done=0. A data_req seen during the data_done cycle is not re-accepted.
  - On acceptance, data_addr, data_we and data_wdata are latched and the next state is DATA.
  - data_req has priority over instr_ready in the same cycle; the handshake is deferred and instr_valid stays 1.
- State DATA:
  - mem_addr = latched address, mem_wdata = latched data, mem_we = latched we.
  - At the edge: data_rdata<=mem_rdata (reads only; unchanged on writes), data_done<=1 for exactly one cycle, next state ISSUE.
  - Latency: data_done rises 2 edges after a request is accepted in ISSUE.
  - pc is not modified by data accesses.
- Fetch latency, counted with instr_ready held at 1:
  - A 1-byte instruction is valid 1 edge after FETCH_OP; throughput is 2 cycles per instruction.
  - A 3-byte instruction is valid 3 edges after FETCH_OP; throughput is 4 cycles per instruction.
- PC arithmetic is 15-bit modulo. pc=0x7FFF increments to 0x0000, including mid-instruction: an opcode at 0x7FFE takes its lo byte from 0x0000.
- mem_wdata holds the latched data outside DATA. Its value there is don't-care but it must not toggle mem_we.

Test Plan:
- RAM[0]=0x04 with instr_ready=1 -> instr_valid=1 one edge after reset release; opcode=0x04, operand=0x0000; pc=1, then FETCH_OP at address 1.
- RAM[1..3]=0x01,0x00,0x20 -> mem_addr 1,2,3 on consecutive cycles; instr_valid with opcode=0x01, operand=0x0020, pc=4.
- 3-byte instruction with hi byte 0xFF, lo byte 0x34 -> operand=0x7F34 (bit 7 dropped).
- Hold instr_ready=0 for 5 cycles -> opcode and operand stable, pc unchanged, mem_we=0 throughout.
- Handshake with jump_en=1, jump_target=0x0000 after JPNZ at 17..19 -> pc=0, next mem_addr=0. Repeat with jump_en=0 -> pc=20.
- In ISSUE: data_req write (addr 0x0022, data 0x09), then read of 0x0022 -> mem_we=1 for one cycle at 0x0022; second data_done gives data_rdata=0x09.
- data_req and instr_ready both 1 in the same cycle -> data access is serviced first and instr_valid stays 1; handshake completes on a later cycle.
- Opcode placed at 0x7FFE -> operand lo byte is fetched from 0x0000 and pc wraps to 0x0001.
- rst asserted during DATA with a write pending -> mem_we=0 that cycle; next cycle pc=0, instr_valid=0, data_done=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch/data sequencer in front of the single-port program/data RAM: owns the PC,
// fetches 1- or 3-byte instructions and slots execute-stage data accesses in while one is held.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [ADDR_W-1:0] instr_operand,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_done,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [2:0] {StFetchOp, StFetchHi, StFetchLo, StIssue, StData} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   opcode_q, opcode_d;
  logic [ADDR_W-1:0]   operand_q, operand_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   daddr_q, daddr_d;
  logic                dwe_q, dwe_d;
  logic [DATA_W-1:0]   dwdata_q, dwdata_d;
  logic [DATA_W-1:0]   drdata_q, drdata_d;
  logic                done_q, done_d;
  logic                is_long;

  // READ, WRITE and JPNZ carry a two-byte operand address
  assign is_long = (mem_rdata == DATA_W'(1)) || (mem_rdata == DATA_W'(2)) ||
                   (mem_rdata == DATA_W'(3));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    valid_d   = valid_q;
    daddr_d   = daddr_q;
    dwe_d     = dwe_q;
    dwdata_d  = dwdata_q;
    drdata_d  = drdata_q;
    done_d    = 1'b0;
    unique case (state_q)
      StFetchOp: begin
        opcode_d  = mem_rdata;
        operand_d = '0;
        pc_d      = pc_q + ADDR_W'(1);
        if (is_long) begin
          state_d = StFetchHi;
        end else begin
          state_d = StIssue;
          valid_d = 1'b1;
        end
      end
      StFetchHi: begin
        operand_d[ADDR_W-1:8] = mem_rdata[ADDR_W-9:0];
        pc_d                  = pc_q + ADDR_W'(1);
        state_d               = StFetchLo;
      end
      StFetchLo: begin
        operand_d[7:0] = mem_rdata[7:0];
        pc_d           = pc_q + ADDR_W'(1);
        valid_d        = 1'b1;
        state_d        = StIssue;
      end
      StIssue: begin
        // A data access wins over the handshake; the done cycle never re-accepts
        if (data_req && !done_q) begin
          daddr_d  = data_addr;
          dwe_d    = data_we;
          dwdata_d = data_wdata;
          state_d  = StData;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          if (jump_en) pc_d = jump_target;
          state_d = StFetchOp;
        end
      end
      StData: begin
        if (!dwe_q) drdata_d = mem_rdata;
        done_d  = 1'b1;
        state_d = StIssue;
      end
      default: state_d = StFetchOp;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetchOp;
      pc_q      <= ADDR_W'(RESET_PC);
      opcode_q  <= '0;
      operand_q <= '0;
      valid_q   <= 1'b0;
      daddr_q   <= '0;
      dwe_q     <= 1'b0;
      dwdata_q  <= '0;
      drdata_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      valid_q   <= valid_d;
      daddr_q   <= daddr_d;
      dwe_q     <= dwe_d;
      dwdata_q  <= dwdata_d;
      drdata_q  <= drdata_d;
      done_q    <= done_d;
    end
  end

  assign mem_addr      = (state_q == StData) ? daddr_q : pc_q;
  assign mem_wdata     = dwdata_q;
  // Reset gates the strobe combinationally so a pending write is dropped at once
  assign mem_we        = (state_q == StData) && dwe_q && !rst;
  assign instr_valid   = valid_q;
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign data_rdata    = drdata_q;
  assign data_done     = done_q;
  assign pc            = pc_q;

endmodule
